// File: rtl/game_pkg.sv
// Shared types and constants for the game step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    DONE  = 2'd2
  } step_state_t;

  localparam int PH_INPUT   = 0;
  localparam int PH_PACMAN  = 1;
  localparam int PH_GHOST   = 2;
  localparam int PH_COLLIDE = 3;
  localparam int NUM_PHASES = 4;

  // One-hot request vector for a phase index.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [1:0] idx);
    logic [NUM_PHASES-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/game_step_sequencer_step_watchdog.sv
// Ack watchdog: counts cycles a phase request has been waiting for ack.
// Latency: expire is high in the ACK_TIMEOUT-th cycle of an unacked request.
// Backpressure: none; clear restarts the count for each new request or ack.
module step_watchdog #(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic active,
  output logic expire
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Wait counter: zero in the first cycle of a request, holds at LAST.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = active && (cnt == LAST);

endmodule

// File: rtl/game_step_sequencer.sv
// Turns each accepted game tick into four ordered phase requests (req/ack).
// Latency: tick at n -> phase_req[0] at n+1; ack at m -> next request at m+1.
// Backpressure: ticks arriving while busy are dropped and counted (saturating).
// Optional ack watchdog enabled by defining GAME_STEP_TIMEOUT_EN.
module game_step_sequencer
  import game_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023,
  parameter int FRAME_W     = 16,
  parameter int OVR_W       = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               game_tick,
  input  logic               pause,
  input  logic [3:0]         phase_ack,
  output logic [3:0]         phase_req,
  output logic               step_busy,
  output logic               step_done,
  output logic [FRAME_W-1:0] frame_count,
  output logic [OVR_W-1:0]   overrun_count,
  output logic               timeout_err
);

  step_state_t state, state_nxt;
  logic [1:0]  ph, ph_nxt;
  logic        ack_hit;
  logic        expire;
  logic        start;
  logic        advance;
  logic [3:0]  req_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  // Only the ack bit of the phase currently requested counts.
  assign ack_hit = (state == PHASE) && phase_ack[ph];

`ifdef GAME_STEP_TIMEOUT_EN
  logic wd_expire;

  step_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_step_watchdog (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (start | advance),
    .active(state == PHASE),
    .expire(wd_expire)
  );

  // An ack arriving in the expiry cycle wins; no error is flagged.
  assign expire = wd_expire & ~ack_hit;

  // Sticky timeout flag, visible from the cycle the next phase starts.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timeout_err <= 1'b0;
    end else if (expire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = |ACK_TIMEOUT;
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    start     = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (game_tick && !pause) begin
          state_nxt = PHASE;
          ph_nxt    = 2'(PH_INPUT);
          start     = 1'b1;
        end
      end
      PHASE: begin
        if (ack_hit || expire) begin
          advance = 1'b1;
          if (ph == 2'(PH_COLLIDE)) begin
            state_nxt = DONE;
            ph_nxt    = 2'(PH_INPUT);
          end else begin
            ph_nxt = ph + 2'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ph_nxt    = 2'(PH_INPUT);
      end
      default: begin
        state_nxt = IDLE;
        ph_nxt    = 2'(PH_INPUT);
      end
    endcase
    req_nxt  = (state_nxt == PHASE) ? phase_onehot(ph_nxt) : 4'b0000;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ph    <= 2'(PH_INPUT);
    end else begin
      state <= state_nxt;
      ph    <= ph_nxt;
    end
  end

  // Registered outputs and frame/overrun counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      phase_req     <= '0;
      step_busy     <= 1'b0;
      step_done     <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      phase_req <= req_nxt;
      step_busy <= busy_nxt;
      step_done <= done_nxt;
      if (done_nxt) begin
        frame_count <= frame_count + 1'b1;
      end
      if (game_tick && (state != IDLE) && (overrun_count != {OVR_W{1'b1}})) begin
        overrun_count <= overrun_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_step_sequencer.sv
// Scoreboard bench for game_step_sequencer: stimulus predicts each phase
// window and step completion from per-phase ack delays; a monitor checks them.
`timescale 1ns/1ps
module tb_game_step_sequencer;

  localparam int T       = 8;
  localparam int FRAME_W = 16;
  localparam int OVR_W   = 8;
`ifdef GAME_STEP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic               game_tick = 1'b0;
  logic               pause = 1'b0;
  logic [3:0]         phase_ack = 4'b0000;
  logic [3:0]         phase_req;
  logic               step_busy;
  logic               step_done;
  logic [FRAME_W-1:0] frame_count;
  logic [OVR_W-1:0]   overrun_count;
  logic               timeout_err;

  game_step_sequencer #(
    .ACK_TIMEOUT(T),
    .FRAME_W    (FRAME_W),
    .OVR_W      (OVR_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .game_tick    (game_tick),
    .pause        (pause),
    .phase_ack    (phase_ack),
    .phase_req    (phase_req),
    .step_busy    (step_busy),
    .step_done    (step_done),
    .frame_count  (frame_count),
    .overrun_count(overrun_count),
    .timeout_err  (timeout_err)
  );

  always #10 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int p; int start; int len; } win_t;
  typedef struct { int at; int frame; bit terr; } done_t;
  win_t  req_q[$];
  done_t done_q[$];
  int    dly_q[$];
  int    acc_m = -1;
  int    done_m = -1;
  int    frame_m = 0;
  int    ovr_m = 0;
  bit    terr_m = 1'b0;
  bit    noise_en = 1'b0;

  function automatic int rnd_d();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 12));
    return 0;
  endfunction

  // One cycle of stimulus; delays apply only if the tick is accepted.
  task automatic drive_cycle(input bit tk, input bit pz,
                             input int d0, input int d1, input int d2, input int d3);
    int n;
    int s;
    int d[4];
    win_t w;
    done_t e;
    @(negedge Clk);
    game_tick = tk;
    pause     = pz;
    n = cyc;
    if (tk) begin
      if (n <= done_m) begin
        if (ovr_m < (1 << OVR_W) - 1) ovr_m++;
      end else if (!pz) begin
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        s = n + 1;
        for (int p = 0; p < 4; p++) begin
          w.p = p;
          w.start = s;
          if (TO_EN && d[p] >= T) begin
            w.len = T;
            terr_m = 1'b1;
          end else begin
            w.len = d[p] + 1;
          end
          req_q.push_back(w);
          dly_q.push_back(d[p]);
          s += w.len;
        end
        frame_m = (frame_m + 1) % (1 << FRAME_W);
        acc_m = n;
        done_m = s;
        e.at = s;
        e.frame = frame_m;
        e.terr = terr_m;
        done_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (cyc <= done_m + 2 && k < 500) begin
      drive_cycle(1'b0, 1'b0, 0, 0, 0, 0);
      k++;
    end
    if (k >= 500) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: step not finished, cycle %0d expected done %0d", cyc, done_m);
    end
  endtask

  // Update-unit responder: acks the active phase after its chosen delay.
  int         rd[4];
  int         rcnt = 0;
  logic [3:0] rprev = 4'b0000;
  always @(negedge Clk) begin
    logic [3:0] a;
    int p;
    a = noise_en ? 4'($urandom) : 4'b0000;
    p = -1;
    if (Reset) begin
      rprev = 4'b0000;
    end else begin
      if (phase_req != rprev) rcnt = 0;
      if (phase_req[0] && !rprev[0] && dly_q.size() >= 4) begin
        for (int i = 0; i < 4; i++) rd[i] = dly_q.pop_front();
      end
      for (int i = 0; i < 4; i++) if (phase_req[i]) p = i;
      if (p >= 0) begin
        for (int j = 0; j < 4; j++) if (j >= p) a[j] = 1'b0;
        if (rcnt == rd[p]) a[p] = 1'b1;
        rcnt++;
      end
      rprev = phase_req;
    end
    phase_ack = a;
  end

  // Monitor: checks each phase window and each step completion.
  logic [3:0] mprev = 4'b0000;
  int         wstart = 0;
  always @(posedge Clk) begin
    win_t w;
    done_t e;
    #1;
    if (Reset) begin
      mprev = 4'b0000;
    end else begin
      if (mprev != 4'b0000 && phase_req != mprev) begin
        if (req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL req_unexpected: got window %b, expected none", mprev);
        end else begin
          w = req_q.pop_front();
          chk("req_pattern", int'(mprev), 1 << w.p);
          chk("req_start", wstart, w.start);
          chk("req_len", cyc - wstart, w.len);
        end
      end
      if (phase_req != 4'b0000 && phase_req != mprev) wstart = cyc;
      chk("req_onehot", $countones(phase_req) <= 1, 1);
      chk("busy", int'(step_busy), int'(cyc > acc_m && cyc <= done_m));
      if (step_done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: got step_done, expected none");
        end else begin
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("done_frame", int'(frame_count), e.frame);
          chk("done_terr", int'(timeout_err), int'(e.terr));
          chk("done_ovr", int'(overrun_count), ovr_m);
        end
      end
      mprev = phase_req;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, int'(phase_req), 0);
    chk({tag, "_busy"}, int'(step_busy), 0);
    chk({tag, "_done"}, int'(step_done), 0);
    chk({tag, "_frame"}, int'(frame_count), 0);
    chk({tag, "_ovr"}, int'(overrun_count), 0);
    chk({tag, "_terr"}, int'(timeout_err), 0);
  endtask

  initial begin
    int k;
    #15;
    chk_all_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Tick at cycle 10, every ack immediate.
    while (cyc < 9) drive_cycle(1'b0, 1'b0, 0, 0, 0, 0);
    drive_cycle(1'b1, 1'b0, 0, 0, 0, 0);
    drain();
    chk("first_frame", int'(frame_count), 1);

    // Pac-Man phase held for 20 cycles.
    drive_cycle(1'b1, 1'b0, 0, 19, 0, 0);
    drain();
    chk("slow_ack_ovr", int'(overrun_count), 0);

    // Pause in IDLE drops ticks without counting them.
    repeat (10) drive_cycle(1'b1, 1'b1, 0, 0, 0, 0);
    drain();
    chk("pause_frame", int'(frame_count), frame_m);
    chk("pause_ovr", int'(overrun_count), 0);

    // Pause raised mid-step does not abort it.
    drive_cycle(1'b1, 1'b0, 0, 0, 6, 0);
    repeat (15) drive_cycle(1'b0, 1'b1, 0, 0, 0, 0);
    drain();

`ifdef GAME_STEP_TIMEOUT_EN
    // Ghost phase never acked: watchdog advances the step.
    drive_cycle(1'b1, 1'b0, 0, 0, 100, 0);
    drain();
    chk("timeout_sticky", int'(timeout_err), 1);
`endif

    // Back-to-back ticks: overrun counter saturates.
    repeat (400) drive_cycle(1'b1, 1'b0, 0, 0, 0, 0);
    drain();
    chk("ovr_saturated", int'(overrun_count), 255);

    // Randomized traffic with ack noise on finished phases.
    noise_en = 1'b1;
    repeat (3000) drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                              rnd_d(), rnd_d(), rnd_d(), rnd_d());
    drain();
    chk("rand_frame", int'(frame_count), frame_m);
    chk("rand_ovr", int'(overrun_count), ovr_m);
    chk("rand_terr", int'(timeout_err), int'(terr_m));

    // Reset while the ghost phase is requested.
    drive_cycle(1'b1, 1'b0, 0, 0, 50, 0);
    k = 0;
    while (phase_req != 4'b0100 && k < 100) begin
      drive_cycle(1'b0, 1'b0, 0, 0, 0, 0);
      k++;
    end
    chk("reach_ghost", int'(phase_req), 4);
    Reset = 1'b1;
    #1;
    chk_all_zero("midstep_reset");
    req_q.delete();
    done_q.delete();
    dly_q.delete();
    acc_m = -1;
    done_m = -1;
    frame_m = 0;
    ovr_m = 0;
    terr_m = 1'b0;
    game_tick = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    drive_cycle(1'b0, 1'b0, 0, 0, 0, 0);
    chk("post_reset_frame", int'(frame_count), 0);
    drive_cycle(1'b1, 1'b0, 0, 0, 0, 0);
    drain();
    chk("post_reset_step", int'(frame_count), 1);

    chk("req_q_empty", req_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
